// File: rtl/ace_kbd_pkg.sv
// ============================================================================
// Module      : ace_kbd_pkg
// Description : Shared constants, decoder state type and scancode lookup for
//               the PS/2 to Jupiter Ace keyboard matrix bridge.
//               The composite-key lookup (sc_to_virt) is only used when
//               ACE_EXTENDED_KEYS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ace_kbd_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;

    localparam logic [2:0] ROW_0 = 3'd0;
    localparam logic [2:0] ROW_1 = 3'd1;
    localparam logic [2:0] ROW_2 = 3'd2;
    localparam logic [2:0] ROW_3 = 3'd3;
    localparam logic [2:0] ROW_4 = 3'd4;
    localparam logic [2:0] ROW_5 = 3'd5;
    localparam logic [2:0] ROW_6 = 3'd6;
    localparam logic [2:0] ROW_7 = 3'd7;

    localparam logic [2:0] COL_0 = 3'd0;
    localparam logic [2:0] COL_1 = 3'd1;
    localparam logic [2:0] COL_2 = 3'd2;
    localparam logic [2:0] COL_3 = 3'd3;
    localparam logic [2:0] COL_4 = 3'd4;

    // Prefix bytes of scancode set 2
    localparam logic [7:0] PREFIX_E0 = 8'hE0;
    localparam logic [7:0] PREFIX_F0 = 8'hF0;

    // Modifiers
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_LCTRL  = 8'h14;

    // Composite keys (backspace is unprefixed, the arrows follow E0)
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } dec_state_t;

    // Packs a valid key position as {valid, row, col}
    function automatic logic [6:0] mk_key(input logic [2:0] row, input logic [2:0] col);
        return {1'b1, row, col};
    endfunction

    // Flat bit position of a key inside the 40-bit matrix
    function automatic logic [5:0] key_index(input logic [2:0] row, input logic [2:0] col);
        return 6'(row) * 6'd5 + 6'(col);
    endfunction

    // Set 2 code to matrix position; no E0-prefixed code maps to a single key
    function automatic logic [6:0] sc_to_key(input logic [7:0] code, input logic ext);
        logic [6:0] k;
        k = 7'd0;
        if (!ext) begin
            case (code)
                SC_LSHIFT, SC_RSHIFT: k = mk_key(ROW_0, COL_0);
                SC_LCTRL:             k = mk_key(ROW_0, COL_1);
                8'h1A: k = mk_key(ROW_0, COL_2);  // Z
                8'h22: k = mk_key(ROW_0, COL_3);  // X
                8'h21: k = mk_key(ROW_0, COL_4);  // C
                8'h1C: k = mk_key(ROW_1, COL_0);  // A
                8'h1B: k = mk_key(ROW_1, COL_1);  // S
                8'h23: k = mk_key(ROW_1, COL_2);  // D
                8'h2B: k = mk_key(ROW_1, COL_3);  // F
                8'h34: k = mk_key(ROW_1, COL_4);  // G
                8'h15: k = mk_key(ROW_2, COL_0);  // Q
                8'h1D: k = mk_key(ROW_2, COL_1);  // W
                8'h24: k = mk_key(ROW_2, COL_2);  // E
                8'h2D: k = mk_key(ROW_2, COL_3);  // R
                8'h2C: k = mk_key(ROW_2, COL_4);  // T
                8'h16: k = mk_key(ROW_3, COL_0);  // 1
                8'h1E: k = mk_key(ROW_3, COL_1);  // 2
                8'h26: k = mk_key(ROW_3, COL_2);  // 3
                8'h25: k = mk_key(ROW_3, COL_3);  // 4
                8'h2E: k = mk_key(ROW_3, COL_4);  // 5
                8'h45: k = mk_key(ROW_4, COL_0);  // 0
                8'h46: k = mk_key(ROW_4, COL_1);  // 9
                8'h3E: k = mk_key(ROW_4, COL_2);  // 8
                8'h3D: k = mk_key(ROW_4, COL_3);  // 7
                8'h36: k = mk_key(ROW_4, COL_4);  // 6
                8'h4D: k = mk_key(ROW_5, COL_0);  // P
                8'h44: k = mk_key(ROW_5, COL_1);  // O
                8'h43: k = mk_key(ROW_5, COL_2);  // I
                8'h3C: k = mk_key(ROW_5, COL_3);  // U
                8'h35: k = mk_key(ROW_5, COL_4);  // Y
                8'h5A: k = mk_key(ROW_6, COL_0);  // ENTER
                8'h4B: k = mk_key(ROW_6, COL_1);  // L
                8'h42: k = mk_key(ROW_6, COL_2);  // K
                8'h3B: k = mk_key(ROW_6, COL_3);  // J
                8'h33: k = mk_key(ROW_6, COL_4);  // H
                8'h29: k = mk_key(ROW_7, COL_0);  // SPACE
                8'h3A: k = mk_key(ROW_7, COL_1);  // M
                8'h31: k = mk_key(ROW_7, COL_2);  // N
                8'h32: k = mk_key(ROW_7, COL_3);  // B
                8'h2A: k = mk_key(ROW_7, COL_4);  // V
                default: k = 7'd0;
            endcase
        end
        return k;
    endfunction

    // Composite key code to {valid, virtual index}
    function automatic logic [3:0] sc_to_virt(input logic [7:0] code, input logic ext);
        logic [3:0] v;
        v = 4'd0;
        if (!ext && code == SC_BKSP) v = {1'b1, 3'd0};
        if (ext) begin
            case (code)
                SC_LEFT:  v = {1'b1, 3'd1};
                SC_DOWN:  v = {1'b1, 3'd2};
                SC_UP:    v = {1'b1, 3'd3};
                SC_RIGHT: v = {1'b1, 3'd4};
                default:  v = 4'd0;
            endcase
        end
        return v;
    endfunction

    // Digit key that each virtual composite key presses together with SHIFT
    function automatic logic [5:0] virt_key_bit(input logic [2:0] idx);
        logic [5:0] b;
        case (idx)
            3'd0:    b = key_index(ROW_4, COL_0);  // 0
            3'd1:    b = key_index(ROW_3, COL_4);  // 5
            3'd2:    b = key_index(ROW_4, COL_4);  // 6
            3'd3:    b = key_index(ROW_4, COL_3);  // 7
            default: b = key_index(ROW_4, COL_2);  // 8
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host receiver: synchronisers, clock glitch
//               filter, 11-bit frame shifter with start/parity/stop checking
//               and an idle timeout that discards partial frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 6500,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic              r_clk_filt, r_clk_filt_d;
    logic [FILT_W-1:0] r_filt_cnt;
    logic [3:0]        r_bit_cnt;
    logic [9:0]        r_shift;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_byte_valid;
    logic [7:0]        r_byte_data;
    logic              w_fall;
    logic [10:0]       w_frame;
    logic              w_frame_ok;

    // Two-flop synchronisers; lines idle high
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Accept a ps2clk level change only after FILTER_LEN consecutive samples
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall     = r_clk_filt_d & ~r_clk_filt;
    // Complete frame as it stands when the stop bit is being sampled
    assign w_frame    = {r_dat_s2, r_shift};
    assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    // Frame shifter, frame check and idle timeout; a falling edge always
    // takes priority over the timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 10'd0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'd0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte_valid <= 1'b1;
                        r_byte_data  <= w_frame[8:1];
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {r_dat_s2, r_shift[9:1]};
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;

endmodule

`default_nettype wire

// File: rtl/ps2_ace_keyboard.sv
// ============================================================================
// Module      : ps2_ace_keyboard
// Description : PS/2 keyboard to Jupiter Ace 8x5 key matrix. Decodes set 2
//               make/break codes into a registered matrix and answers the
//               core's row select combinationally on columnas.
//               Define ACE_EXTENDED_KEYS_EN to enable composite keys
//               (backspace and cursor arrows as SHIFT+digit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_ace_keyboard
    import ace_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6500,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    input  logic [7:0] filas,
    output logic [4:0] columnas
);

    logic        w_byte_valid;
    logic [7:0]  w_byte_data;
    dec_state_t  r_state, w_state_next;
    logic        w_evt, w_evt_break, w_evt_ext;
    logic [6:0]  w_key;
    logic [5:0]  w_key_idx;
    logic [39:0] r_matrix;   // 1 = released, 0 = pressed
    logic [39:0] w_eff;
    logic [4:0]  w_cols;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_ps2_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data)
    );

    // Prefix decoder state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Prefix tracking; any non-prefix byte becomes a key event
    always_comb begin
        w_state_next = r_state;
        w_evt        = 1'b0;
        w_evt_break  = 1'b0;
        w_evt_ext    = 1'b0;
        if (w_byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_data == PREFIX_E0)      w_state_next = ST_E0;
                    else if (w_byte_data == PREFIX_F0) w_state_next = ST_F0;
                    else                               w_evt = 1'b1;
                end
                ST_E0: begin
                    if (w_byte_data == PREFIX_F0) begin
                        w_state_next = ST_E0F0;
                    end else begin
                        w_evt        = 1'b1;
                        w_evt_ext    = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                ST_F0: begin
                    w_evt        = 1'b1;
                    w_evt_break  = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_evt        = 1'b1;
                    w_evt_break  = 1'b1;
                    w_evt_ext    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign w_key     = sc_to_key(w_byte_data, w_evt_ext);
    assign w_key_idx = key_index(w_key[5:3], w_key[2:0]);

    // Physical key matrix: make clears the bit, break sets it
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_matrix <= '1;
        end else if (w_evt && w_key[6]) begin
            r_matrix[w_key_idx] <= w_evt_break;
        end
    end

`ifdef ACE_EXTENDED_KEYS_EN
    logic [4:0] r_virt;
    logic [3:0] w_virt;

    assign w_virt = sc_to_virt(w_byte_data, w_evt_ext);

    // Held composite keys, kept apart so releasing one never releases a
    // physically held SHIFT or digit
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_virt <= 5'd0;
        end else if (w_evt && w_virt[3]) begin
            r_virt[w_virt[2:0]] <= ~w_evt_break;
        end
    end

    // Overlay composite keys on the physical matrix
    always_comb begin
        w_eff = r_matrix;
        if (|r_virt) w_eff[key_index(ROW_0, COL_0)] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (r_virt[i]) w_eff[virt_key_bit(3'(i))] = 1'b0;
        end
    end
`else
    // Without composite keys the visible matrix is the physical one
    always_comb begin
        w_eff = r_matrix;
    end
`endif

    // AND together the column vectors of every selected (low) row
    always_comb begin
        w_cols = 5'b11111;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!filas[r]) w_cols = w_cols & w_eff[r*NUM_COLS +: NUM_COLS];
        end
    end

    assign columnas = w_cols;

endmodule

`default_nettype wire

// File: tb/tb_ps2_ace_keyboard.sv
// ============================================================================
// Module      : tb_ps2_ace_keyboard
// Description : Directed self-checking bench for ps2_ace_keyboard. Expected
//               composite-key results follow ACE_EXTENDED_KEYS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_ace_keyboard;

    localparam int HALF = 30;   // PS/2 half bit period in clk cycles

`ifdef ACE_EXTENDED_KEYS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] filas;
    logic [4:0] columnas;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_ace_keyboard dut (
        .clk      (clk),
        .reset    (reset),
        .ps2clk   (ps2clk),
        .ps2data  (ps2data),
        .filas    (filas),
        .columnas (columnas)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2data = b;
        wait_clk(HALF);
        ps2clk = 1'b0;
        wait_clk(HALF);
        ps2clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; bad_par flips the parity bit
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        ps2data = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
        wait_clk(20);
    endtask

    task automatic probe(input string tag, input logic [7:0] f, input logic [4:0] exp);
        @(negedge clk);
        filas = f;
        #1;
        check(tag, columnas, exp);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        filas   = 8'h00;
        wait_clk(4);
        probe("reset_all_rows", 8'h00, 5'b11111);
        probe("reset_row1",     8'hFD, 5'b11111);
        reset = 1'b1;
        wait_clk(5);
        probe("idle_no_rows", 8'hFF, 5'b11111);

        // Make and break
        send(8'h1C);
        probe("make_A",        8'hFD, 5'b11110);
        probe("make_A_row0",   8'hFE, 5'b11111);
        probe("make_A_none",   8'hFF, 5'b11111);
        send(8'hF0); send(8'h1C);
        probe("break_A",       8'hFD, 5'b11111);

        // Bad parity dropped, next good frame accepted
        send_bits(8'h1C, 1'b1, 11);
        wait_clk(20);
        probe("bad_parity",    8'hFD, 5'b11111);
        send(8'h1C);
        probe("good_after_bad", 8'hFD, 5'b11110);
        send(8'hF0); send(8'h1C);

        // Shift plus Z, multi-row AND
        send(8'h12); send(8'h1A);
        probe("shift_z_row0",  8'hFE, 5'b11010);
        probe("shift_z_all",   8'h00, 5'b11010);
        send(8'h1B);
        probe("multi_row_and", 8'hFC, 5'b11000);
        probe("s_row1",        8'hFD, 5'b11101);
        send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h12);
        probe("break_shift",   8'hFE, 5'b11011);
        send(8'hF0); send(8'h1A);
        probe("release_z",     8'hFE, 5'b11111);

        // Other modifiers
        send(8'h14);
        probe("symshift",      8'hFE, 5'b11101);
        send(8'hF0); send(8'h14);
        send(8'h59);
        probe("rshift",        8'hFE, 5'b11110);
        send(8'hF0); send(8'h59);
        probe("rshift_break",  8'hFE, 5'b11111);

        // E0 with a code that has no extended meaning
        send(8'hE0); send(8'h1C);
        probe("e0_unmapped",   8'hFD, 5'b11111);
        send(8'h1C);
        probe("idle_after_e0", 8'hFD, 5'b11110);
        send(8'hF0); send(8'h1C);

        // Timeout discards partial frame
        send_bits(8'h29, 1'b0, 5);
        wait_clk(13000);
        send(8'h29);
        probe("timeout_space", 8'h7F, 5'b11110);

        // Reset mid-frame clears prefix and partial frame
        send(8'hE0);
        send_bits(8'h1C, 1'b0, 4);
        reset = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(5);
        probe("reset_clears",  8'h7F, 5'b11111);
        send(8'h1C);
        probe("after_midreset", 8'hFD, 5'b11110);
        send(8'hF0); send(8'h1C);

        // Composite keys
        send(8'hE0); send(8'h6B);
        probe("left_shift",    8'hFE, EXT ? 5'b11110 : 5'b11111);
        probe("left_digit5",   8'hF7, EXT ? 5'b01111 : 5'b11111);
        send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h6B);
        probe("phys_shift_kept", 8'hFE, 5'b11110);
        probe("left_released", 8'hF7, 5'b11111);
        send(8'hF0); send(8'h12);
        probe("shift_released", 8'hFE, 5'b11111);
        send(8'h66);
        probe("bksp_digit0",   8'hEF, EXT ? 5'b11110 : 5'b11111);
        probe("bksp_shift",    8'hFE, EXT ? 5'b11110 : 5'b11111);
        send(8'hF0); send(8'h66);
        probe("bksp_released", 8'hEE, 5'b11111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
